seq_mult_unit: RTL

- Multi-cycle shift-add multiplier that sits directly downstream of the 8x8 register file.
- Consumes the two register read ports (OUT1/OUT2) as operands and produces a write-back result, destination address and one-cycle write strobe.
- These outputs feed the register file's IN, INADDRESS and WRITE inputs.
- Adds MUL support to the processor without lengthening the single-cycle ALU path.

---
 rtl/mult_pkg.sv | 19 +
 rtl/seq_mult_unit_if.sv | 27 ++
 rtl/mult_datapath.sv | 64 ++++++
 rtl/seq_mult_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_unit_if.sv
// Request/write-back bundle between the register file side and the multiplier.
interface seq_mult_unit_if
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              START;
    logic [WIDTH-1:0]  DATA1;
    logic [WIDTH-1:0]  DATA2;
    logic [ADDR_W-1:0] DESTADDR;
    logic [WIDTH-1:0]  RESULT;
    logic [ADDR_W-1:0] WRADDR;
    logic              WRITE_EN;
    logic              BUSY;
    logic              OVERFLOW;

    modport master (
        output START, DATA1, DATA2, DESTADDR,
        input  RESULT, WRADDR, WRITE_EN, BUSY, OVERFLOW
    );

    modport slave (
        input  START, DATA1, DATA2, DESTADDR,
        output RESULT, WRADDR, WRITE_EN, BUSY, OVERFLOW
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath: A (shifted multiplicand), B (shifted multiplier), P (partial product).
// With SEQ_MULT_EARLY_TERM_EN defined, also reports when B has run out of set bits.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    output logic [2*WIDTH-1:0] p_next
`ifdef SEQ_MULT_EARLY_TERM_EN
    ,
    output logic               b_zero
`endif
);
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q, b_d;

    // Partial product after this edge; equals P when no iteration is performed.
    always_comb begin
        p_next = p_q + ((step && b_q[0]) ? a_q : '0);
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    // No remaining multiplier bits means P is already final.
    always_comb begin
        b_zero = (b_q == '0);
    end
`endif

    // Load fresh operands on accept, otherwise advance one shift-add iteration per step.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (load) begin
            a_d = {{WIDTH{1'b0}}, data1};
            b_d = data2;
            p_d = '0;
        end else if (step) begin
            p_d = p_next;
            a_d = a_q << 1;
            b_d = b_q >> 1;
        end
    end

    // Datapath registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end
endmodule

// File: rtl/seq_mult_unit.sv
// Multi-cycle unsigned multiplier feeding register file write-back.
// Optional early termination when the multiplier runs out of set bits: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic           CLK,
    input  logic           RESET,
    seq_mult_unit_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                overflow_q, overflow_d;
    logic                dp_load;
    logic                dp_step;
    logic                finish_early;
    logic                complete;
    logic [2*WIDTH-1:0]  p_next;

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic                b_zero;

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (CLK),
        .rst_n  (RESET),
        .load   (dp_load),
        .step   (dp_step),
        .data1  (bus.DATA1),
        .data2  (bus.DATA2),
        .p_next (p_next),
        .b_zero (b_zero)
    );

    // Finish without iterating once no multiplier bits remain.
    always_comb begin
        finish_early = b_zero;
    end
`else
    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (CLK),
        .rst_n  (RESET),
        .load   (dp_load),
        .step   (dp_step),
        .data1  (bus.DATA1),
        .data2  (bus.DATA2),
        .p_next (p_next)
    );

    // Fixed-latency build always runs all WIDTH iterations.
    always_comb begin
        finish_early = 1'b0;
    end
`endif

    // FSM next state, iteration control and completion capture of the product.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wraddr_d   = wraddr_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    dp_load = 1'b1;
                    cnt_d   = '0;
                    addr_d  = bus.DESTADDR;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (finish_early) begin
                    complete = 1'b1;
                end else begin
                    dp_step  = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    complete = (cnt_q == CNT_LAST);
                end
                if (complete) begin
                    result_d   = p_next[WIDTH-1:0];
                    overflow_d = |p_next[2*WIDTH-1:WIDTH];
                    wraddr_d   = addr_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered write-back outputs; reset discards any in-flight result.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wraddr_q   <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wraddr_q   <= wraddr_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.RESULT   = result_q;
    assign bus.WRADDR   = wraddr_q;
    assign bus.OVERFLOW = overflow_q;
    assign bus.BUSY     = (state_q != IDLE);
    assign bus.WRITE_EN = (state_q == DONE);
endmodule
